// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback with a busy-bit scoreboard.
// WB_FIXED_PRIO_EN selects fixed priority (load wins) instead of round-robin.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [ADDR_WIDTH-1:0]    req0_reg,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_WIDTH-1:0]    req1_reg,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  output logic                     req1_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_WIDTH-1:0]    rsv_reg,
  output logic                     RegWrite,
  output logic [ADDR_WIDTH-1:0]    write_reg,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [2**ADDR_WIDTH-1:0] busy
);
  logic                     grant0, grant1, any_grant, do_write;
  logic [ADDR_WIDTH-1:0]    g_reg;
  logic [DATA_WIDTH-1:0]    g_data;
  logic [2**ADDR_WIDTH-1:0] busy_next;
`ifdef WB_FIXED_PRIO_EN
  assign grant0 = req0_valid && !req1_valid;
`else
  logic last_grant;
  assign grant0 = req0_valid && (!req1_valid || last_grant);
`endif
  assign grant1     = req1_valid && !grant0;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign any_grant  = grant0 || grant1;
  assign g_reg      = grant1 ? req1_reg : req0_reg;
  assign g_data     = grant1 ? req1_data : req0_data;
  assign do_write   = any_grant && (g_reg != '0);
  // Reserve is applied after the clear so a back-to-back producer keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (do_write) busy_next[g_reg] = 1'b0;
    if (rsv_valid && rsv_reg != '0) busy_next[rsv_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      busy       <= '0;
    end else begin
      RegWrite <= do_write;
      busy     <= busy_next;
      if (do_write) begin
        write_reg  <= g_reg;
        write_data <= g_data;
      end
    end
  end
`ifndef WB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= 1'b1;
    else if (any_grant) last_grant <= grant1;
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a reference model feeding a scoreboard queue of expected registered outputs.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsv_valid = 1'b0;
  logic [4:0]  req0_reg = '0, req1_reg = '0, rsv_reg = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;
  int tests = 0, fails = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] busy;
  } exp_t;
  exp_t sb[$];

  logic        m_last;
  logic [4:0]  m_reg;
  logic [31:0] m_data, m_busy;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_reg  = '0;
    m_data = '0;
    m_busy = '0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_regwrite"}, 64'(RegWrite), 64'd0);
    chk({tag, "_write_reg"}, 64'(write_reg), 64'd0);
    chk({tag, "_write_data"}, 64'(write_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Entered and left at posedge+1; an idle clock edge during reset release changes nothing.
  task automatic do_reset(input string tag);
    {req0_valid, req1_valid, rsv_valid} = '0;
    rst_n = 1'b0;
    #2;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag,
                       input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic rv, input logic [4:0] rr);
    logic g0, g1, we;
    logic [4:0] gr;
    logic [31:0] gd, nb;
    exp_t e;
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    rsv_valid = rv; rsv_reg = rr;
    #1;
`ifdef WB_FIXED_PRIO_EN
    g0 = v0 && !v1;
`else
    g0 = v0 && (!v1 || m_last);
`endif
    g1 = v1 && !g0;
    chk({tag, "_req0_ready"}, 64'(req0_ready), 64'(g0));
    chk({tag, "_req1_ready"}, 64'(req1_ready), 64'(g1));
    gr = g1 ? r1 : r0;
    gd = g1 ? d1 : d0;
    we = (g0 || g1) && gr != 5'd0;
    nb = m_busy;
    if (we) nb[gr] = 1'b0;
    if (rv && rr != 5'd0) nb[rr] = 1'b1;
    e.we = we;
    e.wreg = we ? gr : m_reg;
    e.wdata = we ? gd : m_data;
    e.busy = nb;
    sb.push_back(e);
`ifndef WB_FIXED_PRIO_EN
    if (g0 || g1) m_last = g1;
`endif
    m_reg = e.wreg;
    m_data = e.wdata;
    m_busy = nb;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_regwrite"}, 64'(RegWrite), 64'(e.we));
    chk({tag, "_write_reg"}, 64'(write_reg), 64'(e.wreg));
    chk({tag, "_write_data"}, 64'(write_data), 64'(e.wdata));
    chk({tag, "_busy"}, 64'(busy), 64'(e.busy));
    {req0_valid, req1_valid, rsv_valid} = '0;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    model_reset();
    do_reset("reset");
    // single ALU write, then idle drops RegWrite but holds address/data
    cycle("single", 1'b1, 5'd3, 32'habcdef12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("single_wr3", 64'(write_reg), 64'd3);
    idle("single_idle");
    // conflict from a fresh reset: round-robin alternates starting with req0
    do_reset("reset2");
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("conflict%0d", i), 1'b1, 5'd4, 32'h1, 1'b1, 5'd5, 32'h2, 1'b0, 5'd0);
`ifdef WB_FIXED_PRIO_EN
      chk($sformatf("conflict%0d_seq", i), 64'(write_reg), 64'd5);
`else
      chk($sformatf("conflict%0d_seq", i), 64'(write_reg), (i % 2 == 0) ? 64'd4 : 64'd5);
`endif
    end
    idle("conflict_idle");
    // reserve, wait, then load completes the register
    cycle("rsv7", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("rsv7_bit", 64'(busy[7]), 64'd1);
    idle("rsv7_idle0");
    idle("rsv7_idle1");
    cycle("ld7", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    chk("ld7_bit", 64'(busy[7]), 64'd0);
    // back-to-back producer: reserve wins over completion of the same register
    cycle("rsv9", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    cycle("b2b9", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("b2b9_bit", 64'(busy[9]), 64'd1);
    // reserve 11 while completing 9: both take effect
    cycle("diff", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9a, 1'b1, 5'd11);
    chk("diff_bits", 64'({busy[11], busy[9]}), 64'b10);
    cycle("ld11", 1'b1, 5'd11, 32'hb, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    // register 0 write is accepted and dropped; reserve of 0 ignored
    cycle("r0", 1'b1, 5'd0, 32'hffffffff, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    chk("r0_busy", 64'(busy), 64'd0);
    // write to a register that was never reserved
    cycle("nonbusy", 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h1234, 1'b0, 5'd0);
    // asynchronous reset mid-cycle with live state
    cycle("pre_a", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);
    cycle("pre_b", 1'b1, 5'd14, 32'hdeadbeef, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("pre_b_live", 64'({RegWrite, busy[13]}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    idle("post_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 is the ALU writeback, req1 is the load/memory writeback.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file write inputs (RegWrite, write_reg, write_data) from registered outputs.
- Keeps a per-register pending-write scoreboard (busy bits) that the decode stage uses for RAW hazard stalls.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register index width; the scoreboard has 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  ADDR_WIDTH  destination register of req0.
- req0_data  in  DATA_WIDTH  write data of req0.
- req0_ready  out  1  req0 accepted this cycle; combinational.
- req1_valid  in  1  load writeback request.
- req1_reg  in  ADDR_WIDTH  destination register of req1.
- req1_data  in  DATA_WIDTH  write data of req1.
- req1_ready  out  1  req1 accepted this cycle; combinational.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_reg  in  ADDR_WIDTH  register to reserve.
- RegWrite  out  1  register file write enable; registered.
- write_reg  out  ADDR_WIDTH  register file write address; registered.
- write_data  out  DATA_WIDTH  register file write data; registered.
- busy  out  2**ADDR_WIDTH  scoreboard; bit r=1 means a write to r is pending; registered.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: RegWrite=0, write_reg=0, write_data=0, busy=0, last_grant=1 (so req0 wins the first conflict).
- Reset is asynchronous and may occur mid-operation. A write accepted in the cycle of reset is lost. Requesters must re-present after reset.
- Handshake:
  - A transfer occurs on an edge where valid=1 and ready=1.
  - A requester holds reg/data stable while valid=1 and ready=0.
  - ready may be 1 while valid=0; this has no effect.
- Arbitration (combinational, one grant per cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant.
  - last_grant updates only on an edge with a grant.
- Output stage, latency 1 cycle:
  - On an edge with a grant to reqN and reqN_reg≠0: RegWrite<=1, write_reg<=reqN_reg, write_data<=reqN_data.
  - On an edge with no grant: RegWrite<=0. write_reg and write_data hold their values.
  - Writes to register 0 are accepted (ready=1) and arbitration state updates, but the write is dropped: RegWrite<=0, and the scoreboard is unchanged.
- There is no backpressure from the register file: its write port accepts every cycle.
- Scoreboard:
  - rsv_valid=1 with rsv_reg≠0 sets busy[rsv_reg] at the edge.
  - A grant to register r≠0 clears busy[r] at the same edge the write is registered.
  - Reserve and write-complete of the same r at the same edge: reserve wins, busy[r]=1. This covers back-to-back producers.
  - Reserve and write-complete of different registers at the same edge: both take effect.
  - busy[0] is always 0.
  - A write to a non-busy register is legal; busy stays 0.
- Up to one reserve and one write per cycle.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority; req1 (load) always wins a conflict; last_grant is unused and held at reset value.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then a single req0 (reg=3, data=32'habcdef12) -> req0_ready=1 that cycle; next cycle RegWrite=1, write_reg=3, write_data=32'habcdef12; the following cycle RegWrite=0.
- req0 (reg=4, 32'h1) and req1 (reg=5, 32'h2) both held valid for 4 cycles -> grants alternate 0,1,0,1; RegWrite stays 1 with write_reg sequence 4,5,4,5. Under WB_FIXED_PRIO_EN: 5,5,5,5 and req0_ready=0 throughout.
- rsv reg=7, then two idle cycles, then req1 (reg=7) accepted -> busy[7]=1 from the edge after the reserve until the edge of the accept, then 0.
- Same edge: rsv_reg=9 and req0 writing reg 9 with busy[9]=1 -> busy[9] stays 1; RegWrite=1, write_reg=9 next cycle.
- req0 write to reg 0 with 32'hffffffff, plus rsv_reg=0 -> req0_ready=1; RegWrite stays 0; busy stays all-zero.
- Assert rst_n=0 asynchronously mid-cycle while RegWrite=1 and busy≠0 -> RegWrite, busy, write_reg and write_data go to 0 immediately, without waiting for clk.
